dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arb_pick.sv | 31 +++
 rtl/dmem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared types and constants for the two-port data-memory
//               arbiter: FSM state encoding, port indices, default burst cap.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // Ownership FSM encoding (explicit width, legacy-compatible constants)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_OWN0 = 2'd1;
  localparam state_t ST_OWN1 = 2'd2;

  // Port indices: 0 = core, 1 = DMA/debug
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Default cap on consecutive locked grants while the other port waits
  localparam int DEFAULT_MAX_BURST = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pick
// Description : Combinational winner selection between two requesters.
//               A lone requester always wins; on a tie the port named by
//               'prio' wins.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic win_valid,
  output logic win
);

  // Pick the winner: tie broken by prio, otherwise the only requester
  always_comb begin
    win_valid = req0 | req1;
    win       = PORT0;
    if (req0 && req1) begin
      win = prio;
    end else if (req1) begin
      win = PORT1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port single-cycle data-memory arbiter with lock-based
//               ownership and a burst cap that hands the memory to the
//               waiting port after MAX_BURST consecutive locked grants.
//               Define DMEM_ARB_RR_EN for round-robin tie breaking in IDLE;
//               otherwise port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [DATA_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [DATA_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [DATA_W-1:0] dm_read_addr,
  output logic [DATA_W-1:0] dm_write_data_rs2,
  output logic              dm_write_en,
  input  logic [DATA_W-1:0] dm_read_data
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              force_vld_q, force_vld_d;
  logic              force_port_q, force_port_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              prio;
  logic              win_valid;
  logic              win;
  logic              gnt0;
  logic              gnt1;
  logic              gnt_any;
  logic [DATA_W-1:0] sel_addr;

`ifdef DMEM_ARB_RR_EN
  logic              rr_q, rr_d;

  // Tie-break preference: a pending burst-cap handoff beats the RR pointer
  always_comb begin
    prio = force_vld_q ? force_port_q : rr_q;
  end
`else
  // Tie-break preference: a pending burst-cap handoff beats fixed port-0 priority
  always_comb begin
    prio = force_vld_q ? force_port_q : PORT0;
  end
`endif

  dmem_arb_pick u_pick (
    .req0      (p0_req),
    .req1      (p1_req),
    .prio      (prio),
    .win_valid (win_valid),
    .win       (win)
  );

  // Grants: arbitration in IDLE, only the owner may access in OWNn
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt0 = win_valid && (win == PORT0);
        gnt1 = win_valid && (win == PORT1);
      end
      ST_OWN0: gnt0 = p0_req;
      ST_OWN1: gnt1 = p1_req;
      default: ;
    endcase
  end

  // Ownership FSM, burst counter and burst-cap handoff
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    force_vld_d  = force_vld_q;
    force_port_d = force_port_q;
`ifdef DMEM_ARB_RR_EN
    rr_d         = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (win_valid) begin
          force_vld_d = 1'b0;
`ifdef DMEM_ARB_RR_EN
          rr_d        = ~win;
`endif
          if ((win == PORT0) ? p0_lock : p1_lock) begin
            state_d = (win == PORT0) ? ST_OWN0 : ST_OWN1;
            cnt_d   = C_ONE;
          end
        end
      end
      ST_OWN0: begin
        if (p0_req && p0_lock) begin
          cnt_d = (cnt_q == C_MAX) ? cnt_q : cnt_q + 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_OWN1: begin
        if (p1_req && p1_lock) begin
          cnt_d = (cnt_q == C_MAX) ? cnt_q : cnt_q + 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Cap reached with the other port waiting: release and hand it the next win
    if (state_d == ST_OWN0 && cnt_d == C_MAX && p1_req) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      force_vld_d  = 1'b1;
      force_port_d = PORT1;
    end else if (state_d == ST_OWN1 && cnt_d == C_MAX && p0_req) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      force_vld_d  = 1'b1;
      force_port_d = PORT0;
    end
  end

  // Datapath: address hold register and per-port read-return registers
  always_comb begin
    gnt_any   = gnt0 | gnt1;
    sel_addr  = gnt1 ? p1_addr : p0_addr;
    addr_d    = gnt_any ? sel_addr : addr_q;
    rvalid0_d = gnt0 & ~p0_we;
    rvalid1_d = gnt1 & ~p1_we;
    rdata0_d  = rvalid0_d ? dm_read_data : rdata0_q;
    rdata1_d  = rvalid1_d ? dm_read_data : rdata1_q;
  end

  // State and datapath registers; reset drops any pending read return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      force_vld_q  <= 1'b0;
      force_port_q <= PORT0;
      addr_q       <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      force_vld_q  <= force_vld_d;
      force_port_q <= force_port_d;
      addr_q       <= addr_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer, starts at port 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= PORT0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Outputs are forced quiet while reset is asserted
  assign p0_gnt            = rst_n & gnt0;
  assign p1_gnt            = rst_n & gnt1;
  assign p0_rvalid         = rvalid0_q;
  assign p1_rvalid         = rvalid1_q;
  assign p0_rdata          = rdata0_q;
  assign p1_rdata          = rdata1_q;
  assign dm_read_addr      = (rst_n & gnt_any) ? sel_addr : addr_q;
  assign dm_write_data_rs2 = gnt1 ? p1_wdata : p0_wdata;
  assign dm_write_en       = rst_n & ((gnt0 & p0_we) | (gnt1 & p1_we));

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A behavioural model
//               predicts grants, memory strobes and read returns; read
//               returns go through a scoreboard queue checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int MAXB = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [2];
  logic        we    [2];
  logic        lock  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, dm_write_en;
  logic [31:0] p0_rdata, p1_rdata, dm_read_addr, dm_write_data_rs2, dm_read_data;

  logic [31:0] mem     [64];
  logic [31:0] mdl_mem [64];

  int     n_checks = 0;
  int     n_err    = 0;
  int     cyc      = 0;
  int     mode     [2];
  logic [1:0] gnt_seen = 2'b00;
  txn_t   stim_q0 [$];
  txn_t   stim_q1 [$];
  exp_t   exp_q0  [$];
  exp_t   exp_q1  [$];
  int     grant_log [$];

  // model state
  int          m_owner = -1;
  int          m_cnt   = 0;
  int          m_rr    = 0;
  int          m_force = -1;
  logic [31:0] m_last_addr = '0;

  dmem_arbiter #(.MAX_BURST(MAXB), .DATA_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .p0_req            (req[0]),
    .p0_we             (we[0]),
    .p0_lock           (lock[0]),
    .p0_addr           (addr[0]),
    .p0_wdata          (wdata[0]),
    .p0_gnt            (p0_gnt),
    .p0_rvalid         (p0_rvalid),
    .p0_rdata          (p0_rdata),
    .p1_req            (req[1]),
    .p1_we             (we[1]),
    .p1_lock           (lock[1]),
    .p1_addr           (addr[1]),
    .p1_wdata          (wdata[1]),
    .p1_gnt            (p1_gnt),
    .p1_rvalid         (p1_rvalid),
    .p1_rdata          (p1_rdata),
    .dm_read_addr      (dm_read_addr),
    .dm_write_data_rs2 (dm_write_data_rs2),
    .dm_write_en       (dm_write_en),
    .dm_read_data      (dm_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory behind the arbiter: combinational read, clocked write, low 6 bits index
  assign dm_read_data = mem[dm_read_addr[5:0]];
  always @(posedge clk) if (dm_write_en) mem[dm_read_addr[5:0]] <= dm_write_data_rs2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference model: predicts this cycle's grant from the arbitration rules
  always @(negedge clk) begin : model
    int          w;
    logic [1:0]  rq;
    logic [31:0] ea;
    exp_t        e;
    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_rr = 0; m_force = -1; m_last_addr = '0;
      exp_q0.delete(); exp_q1.delete();
      chk("rst_gnt",    {30'd0, p1_gnt, p0_gnt}, 32'd0);
      chk("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
      chk("rst_rdata0", p0_rdata, 32'd0);
      chk("rst_rdata1", p1_rdata, 32'd0);
      chk("rst_wen",    {31'd0, dm_write_en}, 32'd0);
      chk("rst_addr",   dm_read_addr, 32'd0);
      gnt_seen = 2'b00;
    end else begin
      rq = {req[1], req[0]};
      w  = -1;
      if (m_owner < 0) begin
        if (rq == 2'b11)  w = (m_force >= 0) ? m_force : (RR ? m_rr : 0);
        else if (rq[0])   w = 0;
        else if (rq[1])   w = 1;
      end else if (rq[m_owner]) begin
        w = m_owner;
      end
      chk("gnt", {30'd0, p1_gnt, p0_gnt}, {30'd0, w == 1, w == 0});
      chk("wen", {31'd0, dm_write_en}, {31'd0, (w >= 0) && we[w]});
      ea = (w >= 0) ? addr[w] : m_last_addr;
      chk("addr", dm_read_addr, ea);
      if (w >= 0) begin
        if (we[w]) begin
          chk("wdata", dm_write_data_rs2, wdata[w]);
          mdl_mem[addr[w][5:0]] = wdata[w];
        end else begin
          e.data = mdl_mem[addr[w][5:0]];
          e.due  = cyc + 1;
          if (w == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        end
        m_last_addr = addr[w];
      end
      grant_log.push_back(w);
      // ownership bookkeeping
      if (m_owner < 0) begin
        if (w >= 0) begin
          m_force = -1;
          m_rr    = 1 - w;
          if (lock[w]) begin m_owner = w; m_cnt = 1; end
        end
      end else if (w == m_owner && lock[w]) begin
        if (m_cnt < MAXB) m_cnt++;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
      if (m_owner >= 0 && m_cnt == MAXB && rq[1 - m_owner]) begin
        m_force = 1 - m_owner; m_owner = -1; m_cnt = 0;
      end
      gnt_seen = {p1_gnt, p0_gnt};
    end
  end

  task automatic mon(input int p, input logic rv, input logic [31:0] rd);
    exp_t f;
    int   n;
    n = (p == 0) ? exp_q0.size() : exp_q1.size();
    if (n > 0) f = (p == 0) ? exp_q0[0] : exp_q1[0];
    if (rv) begin
      if (n == 0) fail($sformatf("rvalid%0d_unexpected", p));
      else begin
        if (p == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        chk($sformatf("rdata%0d", p), rd, f.data);
        chk($sformatf("rvalid%0d_latency", p), cyc, f.due);
      end
    end else if (n > 0 && f.due <= cyc) begin
      fail($sformatf("rvalid%0d_missing", p));
      if (p == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
    end
  endtask

  // Monitor: retire scoreboard entries whenever a read return is presented
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, p0_rvalid, p0_rdata);
      mon(1, p1_rvalid, p1_rdata);
    end
  end

  task automatic set_txn(input int p, input logic w_v, input logic l_v,
                         input logic [31:0] a, input logic [31:0] d);
    req[p] = 1'b1; we[p] = w_v; lock[p] = l_v; addr[p] = a; wdata[p] = d;
  endtask

  // Per-port driver: hold a request until granted, then take the next one
  task automatic drive();
    txn_t t;
    for (int p = 0; p < 2; p++) begin
      if (!req[p] || gnt_seen[p]) begin
        if (p == 0 && exp_sz(stim_q0.size())) begin
          t = stim_q0.pop_front(); set_txn(p, t.we, t.lock, t.addr, t.wdata);
        end else if (p == 1 && exp_sz(stim_q1.size())) begin
          t = stim_q1.pop_front(); set_txn(p, t.we, t.lock, t.addr, t.wdata);
        end else begin
          case (mode[p])
            1: set_txn(p, 1'b0, 1'b0, $urandom, $urandom);
            2: set_txn(p, 1'b0, 1'b1, $urandom, $urandom);
            3: if ($urandom_range(0, 1) == 1)
                 set_txn(p, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom, $urandom);
               else begin req[p] = 1'b0; lock[p] = 1'b0; end
            default: begin req[p] = 1'b0; lock[p] = 1'b0; end
          endcase
        end
      end
    end
  endtask

  function automatic bit exp_sz(input int n);
    return n > 0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    drive();
  endtask

  task automatic push(input int p, input logic w_v, input logic l_v,
                      input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = w_v; t.lock = l_v; t.addr = a; t.wdata = d;
    if (p == 0) stim_q0.push_back(t); else stim_q1.push_back(t);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 64; i++) begin
      mem[i] = i + 2; mdl_mem[i] = i + 2;
    end
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; we[p] = 0; lock[p] = 0; addr[p] = '0; wdata[p] = '0; mode[p] = 0;
    end
    push(0, 1'b0, 1'b0, 32'd3, 32'd0);     // pending during reset, must not be granted
    repeat (3) step();
    @(posedge clk); #1; rst_n = 1'b1;
    stim_q0.delete(); req[0] = 1'b0;
    step();

    // Single read of word 8 (holds 10)
    push(0, 1'b0, 1'b0, 32'd8, 32'd0);
    step();
    @(negedge clk); #1;
    chk("single_gnt", {31'd0, p0_gnt}, 32'd1);
    step();
    @(negedge clk); #1;
    chk("single_rvalid", {31'd0, p0_rvalid}, 32'd1);
    chk("single_rdata", p0_rdata, 32'd10);

    // p1 writes 0x55 to addr 20, then p0 reads it back
    push(1, 1'b1, 1'b0, 32'd20, 32'h55);
    step();
    @(negedge clk); #1;
    chk("wr_wen", {31'd0, dm_write_en}, 32'd1);
    push(0, 1'b0, 1'b0, 32'd20, 32'd0);
    step();
    @(negedge clk); #1;
    chk("wr_wen_pulse", {31'd0, dm_write_en}, 32'd0);
    step();
    @(negedge clk); #1;
    chk("wr_readback", p0_rdata, 32'h55);
    repeat (2) step();

    // Contention: both read continuously, no lock
    @(negedge clk); #1;
    grant_log.delete();
    mode[0] = 1; mode[1] = 1;
    repeat (8) step();
    @(negedge clk); #1;
    chk("cont_len", grant_log.size(), 32'd8);
`ifdef DMEM_ARB_RR_EN
    chk("cont_first_valid", {31'd0, grant_log[0] >= 0}, 32'd1);
    for (int i = 1; i < 8; i++) chk($sformatf("cont_alt%0d", i), grant_log[i], 1 - grant_log[i-1]);
`else
    for (int i = 0; i < 8; i++) chk($sformatf("cont_prio%0d", i), grant_log[i], 32'd0);
`endif
    mode[0] = 0; mode[1] = 0;
    repeat (6) step();

    // Lock burst: p1 locks, p0 arrives one cycle later
    @(negedge clk); #1;
    grant_log.delete();
    mode[1] = 2;
    step();
    push(0, 1'b0, 1'b0, 32'd33, 32'd0);
    repeat (5) step();
    @(negedge clk); #1;
    chk("lock_len", grant_log.size(), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("lock_seq%0d", i), grant_log[i], (i == 4) ? 32'd0 : 32'd1);
    mode[1] = 0;
    repeat (6) step();

    // Reset in the cycle after a read grant
    push(0, 1'b0, 1'b0, 32'd3, 32'd0);
    step();
    @(negedge clk); #1;
    chk("rstrd_gnt", {31'd0, p0_gnt}, 32'd1);
    rst_n = 1'b0;
    step();
    @(negedge clk); #1;
    chk("rstrd_rvalid", {31'd0, p0_rvalid}, 32'd0);
    step();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(1, 1'b0, 1'b0, 32'd5, 32'd0);
    drive();
    @(negedge clk); #1;
    chk("post_rst_gnt", {31'd0, p1_gnt}, 32'd1);
    repeat (3) step();

    // Randomised traffic
    mode[0] = 3; mode[1] = 3;
    repeat (400) step();
    mode[0] = 0; mode[1] = 0;
    repeat (20) step();
    @(negedge clk); #1;
    chk("drain_q0", exp_q0.size(), 32'd0);
    chk("drain_q1", exp_q1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
